serial_addsub: RTL and testbench

- Parameterised bit-serial adder/subtractor. One full-adder cell plus a carry flip-flop processes one operand bit per clock, LSB first.
- Generalises the single-bit decoder-based full adder to WIDTH-bit operands, with add/subtract mode, overflow detection and a start/busy/done handshake.
- Used as an area-cheap arithmetic unit where latency is not critical.

---
 rtl/serial_addsub_pkg.sv | 11 +
 rtl/full_adder_cell.sv | 19 +
 rtl/serial_addsub.sv | 107 ++++++++++
 tb/tb_serial_addsub.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
package serial_addsub_pkg;

    // Controller states: waiting for a request, shifting bits, one-cycle done.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder built from a 3-to-8 one-hot minterm decode.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic c
);

    logic [7:0] dec;

    // One-hot decode of {a,b,cin}; the outputs are ORs of the minterms where each is 1.
    always_comb begin
        dec = 8'b0000_0001 << {a, b, cin};
        s   = dec[1] | dec[2] | dec[4] | dec[7];
        c   = dec[3] | dec[5] | dec[6] | dec[7];
    end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract: one full-adder cell and a carry flop, LSB first,
// WIDTH cycles per operation plus a one-cycle done state.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sha_q, sha_d;
    logic [WIDTH-1:0]   shb_q, shb_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               fa_s, fa_c;

    full_adder_cell u_fa (
        .a   (sha_q[0]),
        .b   (shb_q[0]),
        .cin (carry_q),
        .s   (fa_s),
        .c   (fa_c)
    );

    // Next-state and datapath update; subtract is a + ~b + 1 via the carry seed.
    always_comb begin
        state_d = state_q;
        sha_d   = sha_q;
        shb_d   = shb_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sha_d   = a;
                    shb_d   = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                carry_d = fa_c;
                sha_d   = sha_q >> 1;
                shb_d   = shb_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // carry_q here is the carry into the sign bit.
                    cout_d  = fa_c;
                    ovf_d   = carry_q ^ fa_c;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sha_q   <= '0;
            shb_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sha_q   <= sha_d;
            shb_q   <= shb_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign result   = res_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed self-checking bench for serial_addsub (WIDTH=8).
module tb_serial_addsub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n, start, sub;
    logic [W-1:0] a, b, result;
    logic         busy, done, cout, overflow;

    int checks = 0;
    int errors = 0;

    serial_addsub #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One operation: checks latency, busy length, outputs, and return to idle.
    task automatic run_op(input string tag, input bit s, input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] er, input bit ec, input bit ev);
        int lat, nbusy;
        bit seen;
        @(negedge clk);
        start = 1'b1; sub = s; a = x; b = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; sub = ~s; a = ~x; b = ~y;
        lat = 0; nbusy = 0; seen = 1'b0;
        for (int k = 1; k <= W + 4 && !seen; k++) begin
            if (k > 1) @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                seen = 1'b1;
                lat  = k - 1;
            end
        end
        chk({tag, " done seen"}, 32'(seen), 32'd1);
        chk({tag, " latency"}, lat, W);
        chk({tag, " busy cycles"}, nbusy, W);
        chk({tag, " result"}, result, er);
        chk({tag, " cout"}, cout, ec);
        chk({tag, " overflow"}, overflow, ev);
        @(negedge clk);
        chk({tag, " done pulse end"}, done, 1'b0);
        chk({tag, " idle busy"}, busy, 1'b0);
    endtask

    logic [7:0] ba [4];
    logic [7:0] bb [4];
    logic [7:0] ber[4];
    bit         bs [4];
    bit         bec[4];
    bit         bev[4];

    initial begin
        int  ndone;
        bit  seen;

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset result", result, 8'h00);
        chk("reset cout", cout, 1'b0);
        chk("reset overflow", overflow, 1'b0);
        rst_n = 1'b1;

        run_op("add 0F+01", 1'b0, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0);
        run_op("add FF+01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        run_op("add 7F+01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);

        // Second request during RUN must be dropped.
        @(negedge clk);
        start = 1'b1; sub = 1'b0; a = 8'h10; b = 8'h20;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clk);
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    chk("ignored start result", result, 8'h30);
                    chk("ignored start latency", k - 1, W);
                end
            end
            if (k == 3) begin
                start = 1'b1; a = 8'hAA; b = 8'h55;
            end
            if (k == 4) start = 1'b0;
        end
        chk("ignored start done count", ndone, 1);

        run_op("sub 05-07", 1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0);
        run_op("sub 80-01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);

        // Reset in the middle of RUN aborts and clears everything.
        @(negedge clk);
        start = 1'b1; sub = 1'b0; a = 8'h33; b = 8'h44;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort busy", busy, 1'b0);
        chk("abort done", done, 1'b0);
        chk("abort result", result, 8'h00);
        chk("abort cout", cout, 1'b0);
        chk("abort overflow", overflow, 1'b0);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort no done", ndone, 0);
        run_op("add 01+01", 1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);

        // Back-to-back with start held high; operands change only when a done is seen.
        ba[0] = 8'h12; bb[0] = 8'h34; bs[0] = 1'b0; ber[0] = 8'h46; bec[0] = 1'b0; bev[0] = 1'b0;
        ba[1] = 8'h50; bb[1] = 8'h20; bs[1] = 1'b1; ber[1] = 8'h30; bec[1] = 1'b1; bev[1] = 1'b0;
        ba[2] = 8'hC0; bb[2] = 8'hC0; bs[2] = 1'b0; ber[2] = 8'h80; bec[2] = 1'b1; bev[2] = 1'b0;
        ba[3] = 8'h40; bb[3] = 8'h40; bs[3] = 1'b0; ber[3] = 8'h80; bec[3] = 1'b0; bev[3] = 1'b1;
        @(negedge clk);
        start = 1'b1; sub = bs[0]; a = ba[0]; b = bb[0];
        for (int i = 0; i < 4; i++) begin
            seen = 1'b0;
            for (int k = 0; k < 30 && !seen; k++) begin
                @(negedge clk);
                if (done) seen = 1'b1;
            end
            chk($sformatf("b2b%0d done seen", i), 32'(seen), 32'd1);
            chk($sformatf("b2b%0d result", i), result, ber[i]);
            chk($sformatf("b2b%0d cout", i), cout, bec[i]);
            chk($sformatf("b2b%0d overflow", i), overflow, bev[i]);
            if (i < 3) begin
                sub = bs[i+1]; a = ba[i+1]; b = bb[i+1];
            end else begin
                start = 1'b0;
            end
        end
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("b2b no extra done", ndone, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
